// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, line levels and sizing helper
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // A one-clock bit period still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - modulo-CLKS_PER_BIT cycle counter with bit_end strobe
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - valid/ready fed serialiser producing start, LSB-first data, stop frames
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic [DATA_BITS-1:0] i_TX_DATA,
  input  logic                 i_TX_VALID,
  output logic                 o_TX_READY,
  output logic                 o_TX,
  output logic                 o_TX_BUSY,
  output logic                 o_TX_DONE
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;
  logic                 accept;

  // Ready is forced low during reset so no word is accepted against a clearing FSM.
  assign o_TX_READY = (state_q == IDLE) && !i_RST;
  assign o_TX_BUSY  = (state_q != IDLE);
  assign o_TX       = tx_q;
  assign o_TX_DONE  = done_q;
  assign accept     = i_TX_VALID && o_TX_READY;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (i_CLK),
    .rst    (i_RST),
    .clear  (state_q == IDLE),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = LINE_IDLE;
        if (accept) begin
          shift_d = i_TX_DATA;
          tx_d    = START_LEVEL;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
            tx_d    = STOP_LEVEL;
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= LINE_IDLE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule
